div_16b_seq: RTL and testbench

//  Multi-cycle unsigned N-bit restoring divider for the ALU datapath.

---
 rtl/div_16b_seq.sv | 105 ++++++++++
 tb/tb_div_16b_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/div_16b_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_16b_seq
//  Purpose  : multi-cycle unsigned restoring divider, one trial subtract/cycle
//  Revision : 1.0  initial release
// ============================================================================
module div_16b_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [N-1:0]  dvsr_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [N:0]    rem_shift;
  logic [N:0]    trial;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  quo_next;

  // Start is honoured whenever the unit is not busy, including the DONE cycle.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Full-width shift keeps the bit that falls out of the partial remainder.
  always_comb begin
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    if (!trial[N]) begin
      rem_next = trial[N-1:0];
      quo_next = {quo_q[N-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[N-1:0];
      quo_next = {quo_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dvsr_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvsr_q      <= divisor;
      quo_q       <= dividend;
      rem_q       <= '0;
      cnt         <= CNT_INIT;
      div_by_zero <= 1'b0;
      state       <= (divisor == '0) ? S_ZERO : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            quotient  <= quo_next;
            remainder <= rem_next;
          end
        end
        S_ZERO: begin
          // The untouched shift register still holds the dividend here.
          state       <= S_DONE;
          quotient    <= '1;
          remainder   <= quo_q;
          div_by_zero <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_ZERO);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_16b_seq.sv
`default_nettype none
// Scoreboard bench for div_16b_seq: random and directed divisions vs. a plain-arithmetic model.
module tb_div_16b_seq;
  localparam int N = 16;
  localparam int PERIOD = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  div_16b_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #(PERIOD/2) clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    longint       t_done;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] held_q = '0;
  logic [N-1:0] held_r = '0;
  logic         rst_prev = 1'b0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, otherwise expects held results.
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", div_by_zero, 0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_time", $time, e.t_done);
        held_q = e.q;
        held_r = e.r;
      end
    end else begin
      chk("held_quotient", quotient, held_q);
      chk("held_remainder", remainder, held_r);
    end
    rst_prev = !rst_n;
    if (!rst_n) begin
      sb.delete();
      held_q = '0;
      held_r = '0;
    end
  end

  // Called at posedge+1 with busy==0; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
      e.t_done = longint'($time) + PERIOD + PERIOD/2;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      e.t_done = longint'($time) + N*PERIOD + PERIOD/2;
    end
    sb.push_back(e);
    #1;
    start = 1'b0;
    dividend = N'($urandom);
    divisor = N'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [N-1:0] a, b;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_quotient", quotient, 0);
    chk("init_remainder", remainder, 0);
    chk("init_dbz", div_by_zero, 0);

    issue(16'd100, 16'd7);        wait_done();
    issue(16'hFFFF, 16'h0001);    wait_done();
    issue(16'hFFFF, 16'hFFFF);    wait_done();
    issue(16'd3, 16'd10);         wait_done();
    issue(16'd0, 16'd5);          wait_done();
    issue(16'd5, 16'd0);          wait_done();

    // A start during RUN must be ignored; then a back-to-back start in DONE.
    repeat (3) @(posedge clk); #1;
    issue(16'd100, 16'd7);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    issue(16'd9, 16'd2);          wait_done();

    // Reset lands on the 8th RUN edge; the operation must vanish without a done.
    repeat (2) @(posedge clk); #1;
    issue(16'd100, 16'd7);
    repeat (7) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
    chk("midrun_quotient", quotient, 0);
    chk("midrun_remainder", remainder, 0);
    chk("midrun_dbz", div_by_zero, 0);
    repeat (20) @(posedge clk); #1;
    issue(16'd1000, 16'd33);      wait_done();

    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 15));
        2:       b = N'($urandom_range(16'h8000, 16'hFFFF));
        default: b = N'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(a, b);
      wait_done();
    end

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
